// File: rtl/grid_access_arbiter.sv
// Grid access arbiter: three requesters share one grid RAM port through a
// round-robin grant. Accesses are registered one cycle after the grant, and
// read responses return two cycles after the grant. A clear sequence walks
// every in-range cell and writes zero to it, one cell per cycle.
module grid_access_arbiter #(
  parameter int         GRID_Y   = 24,
  parameter logic [3:0] OOR_CODE = 4'b0010
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  req_valid,
  input  logic [2:0]  req_we,
  input  logic [14:0] req_x,
  input  logic [14:0] req_y,
  input  logic [11:0] req_wdata,
  output logic [2:0]  req_ready,
  output logic [2:0]  rsp_valid,
  output logic [3:0]  rsp_data,
  input  logic        clear_start,
  output logic        clear_busy,
  output logic        mem_en,
  output logic        mem_we,
  output logic [9:0]  mem_addr,
  output logic [3:0]  mem_wdata,
  input  logic [3:0]  mem_rdata
);

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  // Last address of the clear walk: {y, x} with y = GRID_Y-1, x = 31.
  localparam logic [9:0] CLR_LAST = 10'(32 * GRID_Y - 1);
  // One extra bit so that GRID_Y = 32 still compares correctly.
  localparam logic [5:0] GRID_Y_L = 6'(GRID_Y);

  state_t      state_q, state_d;
  logic [1:0]  last_grant_q, last_grant_d;
  logic [9:0]  clr_cnt_q, clr_cnt_d;
  logic        mem_en_q, mem_en_d;
  logic        mem_we_q, mem_we_d;
  logic [9:0]  mem_addr_q, mem_addr_d;
  logic [3:0]  mem_wdata_q, mem_wdata_d;
  logic [2:0]  rd_pend_q, rd_pend_d;
  logic        rd_oor_q, rd_oor_d;
  logic [2:0]  rsp_valid_q, rsp_valid_d;
  logic        rsp_oor_q, rsp_oor_d;
  logic [3:0]  rsp_hold_q, rsp_hold_d;

  logic [2:0]  grant_s;
  logic [1:0]  gidx_s;
  logic        sel_we_s;
  logic [4:0]  sel_x_s;
  logic [4:0]  sel_y_s;
  logic [3:0]  sel_wdata_s;
  logic        in_range_s;
  logic [3:0]  rsp_data_s;

  // Round-robin pick: search starts at the requester after the last grant.
  function automatic logic [2:0] rr_pick(input logic [2:0] valid, input logic [1:0] last);
    logic [2:0] g;
    g = 3'b000;
    case (last)
      2'd0: begin
        if (valid[1])      g = 3'b010;
        else if (valid[2]) g = 3'b100;
        else if (valid[0]) g = 3'b001;
        else               g = 3'b000;
      end
      2'd1: begin
        if (valid[2])      g = 3'b100;
        else if (valid[0]) g = 3'b001;
        else if (valid[1]) g = 3'b010;
        else               g = 3'b000;
      end
      default: begin
        if (valid[0])      g = 3'b001;
        else if (valid[1]) g = 3'b010;
        else if (valid[2]) g = 3'b100;
        else               g = 3'b000;
      end
    endcase
    return g;
  endfunction

  // Select the winning requester's fields.
  always_comb begin
    gidx_s      = 2'd0;
    sel_we_s    = req_we[0];
    sel_x_s     = req_x[4:0];
    sel_y_s     = req_y[4:0];
    sel_wdata_s = req_wdata[3:0];
    case (grant_s)
      3'b010: begin
        gidx_s      = 2'd1;
        sel_we_s    = req_we[1];
        sel_x_s     = req_x[9:5];
        sel_y_s     = req_y[9:5];
        sel_wdata_s = req_wdata[7:4];
      end
      3'b100: begin
        gidx_s      = 2'd2;
        sel_we_s    = req_we[2];
        sel_x_s     = req_x[14:10];
        sel_y_s     = req_y[14:10];
        sel_wdata_s = req_wdata[11:8];
      end
      default: begin
        gidx_s      = 2'd0;
        sel_we_s    = req_we[0];
        sel_x_s     = req_x[4:0];
        sel_y_s     = req_y[4:0];
        sel_wdata_s = req_wdata[3:0];
      end
    endcase
    in_range_s = ({1'b0, sel_y_s} < GRID_Y_L);
  end

  // Read data: live RAM data (or the out-of-range code) while a response is
  // strobed, otherwise the last delivered value.
  always_comb begin
    if (rsp_valid_q != 3'b000) begin
      rsp_data_s = rsp_oor_q ? OOR_CODE : mem_rdata;
    end else begin
      rsp_data_s = rsp_hold_q;
    end
  end

  // Next-state logic: arbitration, access staging, clear walk, response pipe.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    clr_cnt_d    = clr_cnt_q;
    mem_en_d     = 1'b0;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    rd_pend_d    = 3'b000;
    rd_oor_d     = 1'b0;
    rsp_valid_d  = rd_pend_q;
    rsp_oor_d    = rd_oor_q;
    grant_s      = 3'b000;
    if (rsp_valid_q != 3'b000) begin
      rsp_hold_d = rsp_data_s;
    end else begin
      rsp_hold_d = rsp_hold_q;
    end

    case (state_q)
      IDLE: begin
        if (clear_start) begin
          // Clear wins over any request presented in the same cycle.
          state_d   = CLEAR;
          clr_cnt_d = 10'd0;
        end else begin
          grant_s = rr_pick(req_valid, last_grant_q);
          if (grant_s != 3'b000) begin
            last_grant_d = gidx_s;
            if (in_range_s) begin
              mem_en_d    = 1'b1;
              mem_we_d    = sel_we_s;
              mem_addr_d  = {sel_y_s, sel_x_s};
              mem_wdata_d = sel_wdata_s;
            end else begin
              mem_en_d = 1'b0;
            end
            if (!sel_we_s) begin
              rd_pend_d = grant_s;
              rd_oor_d  = !in_range_s;
            end else begin
              rd_pend_d = 3'b000;
            end
          end else begin
            last_grant_d = last_grant_q;
          end
        end
      end
      CLEAR: begin
        mem_en_d    = 1'b1;
        mem_we_d    = 1'b1;
        mem_addr_d  = clr_cnt_q;
        mem_wdata_d = 4'b0000;
        if (clr_cnt_q == CLR_LAST) begin
          state_d   = IDLE;
          clr_cnt_d = 10'd0;
        end else begin
          clr_cnt_d = clr_cnt_q + 10'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and pipeline registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 2'd2;
      clr_cnt_q    <= 10'd0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= 10'd0;
      mem_wdata_q  <= 4'd0;
      rd_pend_q    <= 3'b000;
      rd_oor_q     <= 1'b0;
      rsp_valid_q  <= 3'b000;
      rsp_oor_q    <= 1'b0;
      rsp_hold_q   <= 4'd0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      clr_cnt_q    <= clr_cnt_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      rd_pend_q    <= rd_pend_d;
      rd_oor_q     <= rd_oor_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_oor_q    <= rsp_oor_d;
      rsp_hold_q   <= rsp_hold_d;
    end
  end

  // Grants are combinational but held at zero while reset is asserted.
  assign req_ready  = rst ? 3'b000 : grant_s;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_data   = rsp_data_s;
  assign clear_busy = (state_q == CLEAR);
  assign mem_en     = mem_en_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;

endmodule
